// File: rtl/conv_col_feeder_pkg.sv
// Shared definitions for the convolver column feeder.
// Build option: CONV_COL_FEEDER_PAD_EN adds one zero column on each side of the image.
package conv_col_feeder_pkg;

  localparam int BIT_LEN_DEF  = 8;
  localparam int ADDR_LEN_DEF = 10;

`ifdef CONV_COL_FEEDER_PAD_EN
  localparam int PAD_COLS = 1;
`else
  localparam int PAD_COLS = 0;
`endif

  // Narrowest image that still yields at least one 3x3 window.
  localparam int MIN_WIDTH = 3 - 2 * PAD_COLS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KLOAD,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam logic SEL_KERNEL = 1'b0;
  localparam logic SEL_IMAGE  = 1'b1;

  // Flat index of kernel element (r,c) inside the packed coefficient bus.
  function automatic int kidx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/conv_col_rdpipe.sv
// Line-memory read sequencer, 1-cycle return register and result-valid regeneration.
// Build option: CONV_COL_FEEDER_PAD_EN (only affects when the parent issues go).
import conv_col_feeder_pkg::*;

module conv_col_rdpipe #(
  parameter int BIT_LEN  = BIT_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [ADDR_LEN-1:0]   width,
  input  logic                  img_valid,
  input  logic [3*BIT_LEN-1:0]  col_in,
  output logic                  rd_en,
  output logic [ADDR_LEN-1:0]   addr,
  output logic [3*BIT_LEN-1:0]  col_q,
  output logic                  res_valid
);

  localparam logic [ADDR_LEN-1:0] ADDR_ONE  = ADDR_LEN'(1);
  localparam logic [ADDR_LEN+1:0] IDX_ONE   = (ADDR_LEN+2)'(1);
  localparam logic [ADDR_LEN+1:0] FIRST_RES = (ADDR_LEN+2)'(3);

  logic [ADDR_LEN-1:0] left;
  logic                rd_d;
  logic [ADDR_LEN+1:0] img_idx;

  // Issue one read per cycle for addresses 0..width-1 once go fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en <= 1'b0;
      addr  <= '0;
      left  <= '0;
    end else if (go) begin
      rd_en <= 1'b1;
      addr  <= '0;
      left  <= width - ADDR_ONE;
    end else if (rd_en) begin
      if (left == '0) begin
        rd_en <= 1'b0;
      end else begin
        addr <= addr + ADDR_ONE;
        left <= left - ADDR_ONE;
      end
    end
  end

  // Capture returned data one cycle after each read; zero when nothing was read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d  <= 1'b0;
      col_q <= '0;
    end else begin
      rd_d  <= rd_en;
      col_q <= rd_d ? col_in : '0;
    end
  end

  // Image valids are contiguous, so the index restarts whenever they stop;
  // a window is complete from the fourth image column onward.
  always_ff @(posedge clk) begin
    if (reset) begin
      img_idx   <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= img_valid && (img_idx >= FIRST_RES);
      img_idx   <= img_valid ? img_idx + IDX_ONE : '0;
    end
  end

endmodule

// File: rtl/conv_col_feeder.sv
// Column-triplet source for the 3x3 convolver: kernel load, image stream, flush.
// Build option: CONV_COL_FEEDER_PAD_EN inserts a zero column before and after the image.
//
// state  | meaning
// IDLE   | waiting for an accepted start
// KLOAD  | three kernel columns, select=0
// STREAM | image columns (plus pad columns when enabled), select=1
// FLUSH  | one all-zero column pushing out the last window
// DONE   | one-cycle completion pulse
import conv_col_feeder_pkg::*;

module conv_col_feeder #(
  parameter int BIT_LEN  = BIT_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_LEN-1:0]   i_width,
  input  logic [9*BIT_LEN-1:0]  i_kernel,
  input  logic [3*BIT_LEN-1:0]  i_col,
  output logic                  o_rd_en,
  output logic [ADDR_LEN-1:0]   o_addr,
  output logic [BIT_LEN-1:0]    o_dato0,
  output logic [BIT_LEN-1:0]    o_dato1,
  output logic [BIT_LEN-1:0]    o_dato2,
  output logic                  o_valid,
  output logic                  o_selecK_I,
  output logic                  o_res_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_LEN-1:0] MIN_W     = ADDR_LEN'(MIN_WIDTH);
  localparam logic [ADDR_LEN:0]   CNT_ONE   = (ADDR_LEN+1)'(1);
  localparam logic [ADDR_LEN:0]   KLOAD_CNT = (ADDR_LEN+1)'(2);
  localparam logic [ADDR_LEN:0]   PAD_EXTRA = (ADDR_LEN+1)'(2 * PAD_COLS);
  // Reads start in KLOAD step 0, or step 1 when a leading pad column is inserted.
  localparam logic [ADDR_LEN:0]   RD_GO_CNT = (ADDR_LEN+1)'(2 - PAD_COLS);

  state_t               state, state_nxt;
  logic [ADDR_LEN:0]    cnt, cnt_nxt;
  logic [ADDR_LEN-1:0]  width_q;
  logic [9*BIT_LEN-1:0] kernel_q;
  logic                 accept;
  logic                 rd_go;
  logic [1:0]           kstep;
  logic [3*BIT_LEN-1:0] col_q;

  // State, down-counter and run parameters captured at start.
  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      width_q  <= '0;
      kernel_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        width_q  <= i_width;
        kernel_q <= i_kernel;
      end
    end
  end

  // Next-state and output decode; o_dato is zero whenever valid is low.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    rd_go      = 1'b0;
    kstep      = 2'd2 - cnt[1:0];
    o_valid    = 1'b0;
    o_selecK_I = SEL_KERNEL;
    o_dato0    = '0;
    o_dato1    = '0;
    o_dato2    = '0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start && (i_width >= MIN_W)) begin
          accept    = 1'b1;
          state_nxt = ST_KLOAD;
          cnt_nxt   = KLOAD_CNT;
        end
      end
      ST_KLOAD: begin
        o_valid = 1'b1;
        o_dato0 = kernel_q[kidx(int'(kstep), 0)*BIT_LEN +: BIT_LEN];
        o_dato1 = kernel_q[kidx(int'(kstep), 1)*BIT_LEN +: BIT_LEN];
        o_dato2 = kernel_q[kidx(int'(kstep), 2)*BIT_LEN +: BIT_LEN];
        rd_go   = (cnt == RD_GO_CNT);
        if (cnt == '0) begin
          state_nxt = ST_STREAM;
          cnt_nxt   = {1'b0, width_q} + PAD_EXTRA - CNT_ONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_STREAM: begin
        o_valid    = 1'b1;
        o_selecK_I = SEL_IMAGE;
        {o_dato2, o_dato1, o_dato0} = col_q;
        if (cnt == '0) begin
          state_nxt = ST_FLUSH;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_FLUSH: begin
        o_valid    = 1'b1;
        o_selecK_I = SEL_IMAGE;
        state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  conv_col_rdpipe #(
    .BIT_LEN  (BIT_LEN),
    .ADDR_LEN (ADDR_LEN)
  ) u_rdpipe (
    .clk       (CLK100MHZ),
    .reset     (i_reset),
    .go        (rd_go),
    .width     (width_q),
    .img_valid (o_valid && (o_selecK_I == SEL_IMAGE)),
    .col_in    (i_col),
    .rd_en     (o_rd_en),
    .addr      (o_addr),
    .col_q     (col_q),
    .res_valid (o_res_valid)
  );

endmodule

// File: tb/tb_conv_col_feeder.sv
// Self-checking bench for conv_col_feeder; honours CONV_COL_FEEDER_PAD_EN.
module tb_conv_col_feeder;

  localparam int BL = 8;
  localparam int AL = 10;
`ifdef CONV_COL_FEEDER_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_reset, i_start;
  logic [AL-1:0]   i_width;
  logic [9*BL-1:0] i_kernel;
  logic [3*BL-1:0] i_col;
  logic            o_rd_en, o_valid, o_selecK_I, o_res_valid, o_busy, o_done;
  logic [AL-1:0]   o_addr;
  logic [BL-1:0]   o_dato0, o_dato1, o_dato2;

  conv_col_feeder #(.BIT_LEN(BL), .ADDR_LEN(AL)) dut (
    .CLK100MHZ   (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_width     (i_width),
    .i_kernel    (i_kernel),
    .i_col       (i_col),
    .o_rd_en     (o_rd_en),
    .o_addr      (o_addr),
    .o_dato0     (o_dato0),
    .o_dato1     (o_dato1),
    .o_dato2     (o_dato2),
    .o_valid     (o_valid),
    .o_selecK_I  (o_selecK_I),
    .o_res_valid (o_res_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  typedef struct packed {
    logic          rd_en;
    logic [AL-1:0] addr;
    logic [BL-1:0] d0;
    logic [BL-1:0] d1;
    logic [BL-1:0] d2;
    logic          valid;
    logic          sel;
    logic          res;
    logic          busy;
    logic          done;
  } obs_t;

  typedef struct {
    int w;
    int restart_cyc;
    int restart_w;
    int rst_cyc;
    bit kfixed;
    bit exp_acc;
    int exp_done;
    int exp_res;
  } vec_t;

  logic [3*BL-1:0] mem [1024];
  int checks;
  int failures;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Expected outputs in cycle t of a run, derived directly from the timing rules.
  function automatic obs_t model(input int t, input int w, input bit acc, input int rst_cyc,
                                 input logic [9*BL-1:0] k);
    obs_t o;
    int e, col;
    o = '0;
    if (!acc) return o;
    if (rst_cyc >= 0 && t > rst_cyc) return o;
    e = w + 2 * P;
    o.valid = (t >= 1 && t <= e + 4);
    o.sel   = (t >= 4 && t <= e + 4);
    if (t >= 1 && t <= 3) begin
      o.d0 = k[(3 * (t - 1) + 0) * BL +: BL];
      o.d1 = k[(3 * (t - 1) + 1) * BL +: BL];
      o.d2 = k[(3 * (t - 1) + 2) * BL +: BL];
    end else if (t >= 4 && t <= e + 3) begin
      col = t - 4 - P;
      if (col >= 0 && col < w) {o.d2, o.d1, o.d0} = mem[col];
    end
    col = t - 2 - P;
    if (col >= 0 && col < w) begin
      o.rd_en = 1'b1;
      o.addr  = AL'(col);
    end
    o.res  = (t >= 8 && t <= e + 5);
    o.busy = (t >= 1 && t <= e + 5);
    o.done = (t == e + 5);
    return o;
  endfunction

  task automatic run_case(input int idx, input vec_t v);
    logic [9*BL-1:0] k;
    obs_t exp_o, act;
    bit prev_rd;
    logic [AL-1:0] prev_addr;
    int done_cyc, res_cnt, tlen;
    bit acc_seen;
    for (int i = 0; i < v.w; i++) mem[i] = (3*BL)'($urandom);
    if (v.kfixed) begin
      for (int i = 0; i < 9; i++) k[i*BL +: BL] = BL'(i + 1);
    end else begin
      k = (9*BL)'({$urandom, $urandom, $urandom});
    end
    tlen = v.w + 2 * P + 12;
    prev_rd = 1'b0;
    prev_addr = '0;
    done_cyc = -1;
    res_cnt = 0;
    acc_seen = 1'b0;
    for (int t = 0; t < tlen; t++) begin
      i_start  = (t == 0) || (t == v.restart_cyc);
      i_reset  = (t == v.rst_cyc);
      if (t == 0) begin
        i_width  = AL'(v.w);
        i_kernel = k;
      end else begin
        i_width  = (t == v.restart_cyc) ? AL'(v.restart_w) : AL'($urandom);
        i_kernel = (9*BL)'({$urandom, $urandom, $urandom});
      end
      i_col = prev_rd ? mem[prev_addr] : (3*BL)'($urandom);
      @(negedge clk);
      act = {o_rd_en, o_addr, o_dato0, o_dato1, o_dato2,
             o_valid, o_selecK_I, o_res_valid, o_busy, o_done};
      exp_o = model(t, v.w, v.exp_acc, v.rst_cyc, k);
      if (!exp_o.rd_en) act.addr = '0;
      chk($sformatf("case%0d_cycle%0d", idx, t), 64'(act), 64'(exp_o));
      prev_rd = o_rd_en;
      prev_addr = o_addr;
      if (o_done && done_cyc < 0) done_cyc = t;
      if (o_res_valid) res_cnt++;
      if (t == 1) acc_seen = o_busy;
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    i_reset = 1'b0;
    chk($sformatf("case%0d_accept", idx), 64'(acc_seen), 64'(v.exp_acc));
    chk($sformatf("case%0d_done_cycle", idx), 64'(done_cyc), 64'(v.exp_done));
    chk($sformatf("case%0d_res_count", idx), 64'(res_cnt), 64'(v.exp_res));
  endtask

  vec_t vecs [10];

  initial begin
    obs_t act;
    checks = 0;
    failures = 0;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_width = '0;
    i_kernel = '0;
    i_col = '0;
    repeat (3) @(posedge clk);
    #1;
    i_start = 1'b1;
    i_width = AL'(4);
    @(negedge clk);
    act = {o_rd_en, o_addr, o_dato0, o_dato1, o_dato2,
           o_valid, o_selecK_I, o_res_valid, o_busy, o_done};
    chk("reset_state", 64'(act), 64'(0));
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_reset = 1'b0;
    @(negedge clk);
    chk("start_under_reset_ignored", 64'(o_busy), 64'(0));
    @(posedge clk);
    #1;

    //            w  rcyc rw  rst kf acc done res
`ifdef CONV_COL_FEEDER_PAD_EN
    vecs[0] = '{4,  -1, 0, -1, 1, 1, 11,  4};
    vecs[1] = '{16, -1, 0, -1, 0, 1, 23, 16};
    vecs[2] = '{8,   5, 5, -1, 0, 1, 15,  8};
    vecs[3] = '{8,   5, 2, -1, 0, 1, 15,  8};
    vecs[4] = '{2,  -1, 0, -1, 0, 1,  9,  2};
    vecs[5] = '{0,  -1, 0, -1, 0, 0, -1,  0};
    vecs[6] = '{3,  -1, 0, -1, 0, 1, 10,  3};
    vecs[7] = '{8,  -1, 0,  6, 0, 1, -1,  0};
    vecs[8] = '{4,  -1, 0, -1, 1, 1, 11,  4};
    vecs[9] = '{1,  -1, 0, -1, 0, 1,  8,  1};
`else
    vecs[0] = '{4,  -1, 0, -1, 1, 1,  9,  2};
    vecs[1] = '{16, -1, 0, -1, 0, 1, 21, 14};
    vecs[2] = '{8,   5, 5, -1, 0, 1, 13,  6};
    vecs[3] = '{8,   5, 2, -1, 0, 1, 13,  6};
    vecs[4] = '{2,  -1, 0, -1, 0, 0, -1,  0};
    vecs[5] = '{0,  -1, 0, -1, 0, 0, -1,  0};
    vecs[6] = '{3,  -1, 0, -1, 0, 1,  8,  1};
    vecs[7] = '{8,  -1, 0,  6, 0, 1, -1,  0};
    vecs[8] = '{4,  -1, 0, -1, 1, 1,  9,  2};
    vecs[9] = '{37, -1, 0, -1, 0, 1, 42, 35};
`endif

    for (int i = 0; i < 10; i++) run_case(i, vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
